fsb_trace_replay: RTL and testbench

ROM-driven trace replay engine used as the stimulus/checker front end of block-level benches. Each cycle it fetches a 4-bit opcode plus a ring_width_p-bit payload from an external combinational ROM. It then either sends the payload to the DUT, receives DUT output and compares it against the payload, waits, or stops. Sits between a trace ROM and the DUT's input/output streams; done_o and error_o report run status.

---
 rtl/fsb_trace_replay_pkg.sv | 25 ++
 rtl/fsb_trace_replay.sv | 132 +++++++++++++
 tb/tb_fsb_trace_replay.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsb_trace_replay_pkg.sv
// Shared opcode and state definitions for the ROM-driven trace replay engine.
package fsb_trace_replay_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_WAIT     = 4'd0,
        OP_SEND     = 4'd1,
        OP_RECV     = 4'd2,
        OP_DONE     = 4'd3,
        OP_FINISH   = 4'd4,
        OP_CTR_INIT = 4'd5,
        OP_CTR_WAIT = 4'd6
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
        return op <= OP_CTR_WAIT;
    endfunction

endpackage

// File: rtl/fsb_trace_replay.sv
// Trace replay engine: fetches {opcode, payload} from a combinational ROM and
// sends, receives/compares, waits or stops; done/error flags are sticky.
module fsb_trace_replay
    import fsb_trace_replay_pkg::*;
#(
    parameter int unsigned ring_width_p     = 80,
    parameter int unsigned rom_addr_width_p = 32,
    parameter int unsigned counter_width_p  = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          en_i,

    input  logic                          v_i,
    input  logic [ring_width_p-1:0]       data_i,
    output logic                          ready_o,

    output logic                          v_o,
    output logic [ring_width_p-1:0]       data_o,
    input  logic                          yumi_i,

    output logic [rom_addr_width_p-1:0]   rom_addr_o,
    input  logic [ring_width_p+3:0]       rom_data_i,

    output logic                          done_o,
    output logic                          error_o
);

    state_e                        state_q, state_d;
    logic [rom_addr_width_p-1:0]   addr_q, addr_d, addr_inc;
    logic [counter_width_p-1:0]    ctr_q, ctr_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;

    logic [OPCODE_WIDTH-1:0]       op;
    logic [ring_width_p-1:0]       payload;
    logic                          recv_miss;
    logic                          finish_hit;

    assign op       = rom_data_i[ring_width_p +: OPCODE_WIDTH];
    assign payload  = rom_data_i[ring_width_p-1:0];
    assign addr_inc = addr_q + rom_addr_width_p'(1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ctr_d      = ctr_q;
        done_d     = done_q;
        error_d    = error_q;
        recv_miss  = 1'b0;
        finish_hit = 1'b0;
        v_o        = 1'b0;
        ready_o    = 1'b0;

        if (en_i && !reset_i && state_q == ST_RUN) begin
            if (!is_legal_op(op)) begin
                error_d = 1'b1;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                case (op)
                    OP_WAIT: addr_d = addr_inc;
                    OP_SEND: begin
                        v_o = 1'b1;
                        if (yumi_i) addr_d = addr_inc;
                    end
                    OP_RECV: begin
                        ready_o = 1'b1;
                        // Advance on the handshake even when the compare fails.
                        if (v_i) begin
                            addr_d = addr_inc;
                            if (data_i != payload) begin
                                recv_miss = 1'b1;
                                error_d   = 1'b1;
                            end
                        end
                    end
                    OP_DONE: begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                    OP_FINISH: begin
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                        finish_hit = 1'b1;
                    end
                    OP_CTR_INIT: begin
                        ctr_d  = payload[counter_width_p-1:0];
                        addr_d = addr_inc;
                    end
                    OP_CTR_WAIT: begin
                        if (ctr_q == '0) addr_d = addr_inc;
                        else             ctr_d  = ctr_q - counter_width_p'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            ctr_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ctr_q   <= ctr_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (recv_miss)
            $display("fsb_trace_replay: recv at addr %0d expected %h actual %h",
                     addr_q, payload, data_i);
        if (finish_hit)
            $finish;
    end
`endif

    assign data_o     = payload;
    assign rom_addr_o = addr_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_fsb_trace_replay.sv
// Self-checking bench for fsb_trace_replay: single-instruction vector table
// plus multi-cycle sequences, all compared through an expectation queue.
module tb_fsb_trace_replay;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset, en, v_in, yumi;
    logic          ready, v_out, done, err;
    logic [W-1:0]  data_in, data_out;
    logic [AW-1:0] addr;
    logic [W+3:0]  rom_data;
    logic [W+3:0]  rom [0:15];

    always #5 clk = ~clk;

    assign rom_data = rom[addr[3:0]];

    fsb_trace_replay #(
        .ring_width_p    (W),
        .rom_addr_width_p(AW),
        .counter_width_p (CW)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (en),
        .v_i       (v_in),
        .data_i    (data_in),
        .ready_o   (ready),
        .v_o       (v_out),
        .data_o    (data_out),
        .yumi_i    (yumi),
        .rom_addr_o(addr),
        .rom_data_i(rom_data),
        .done_o    (done),
        .error_o   (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // kind 0: combinational outputs (v, rdy, data); kind 1: state (addr, done, err)
    typedef struct {
        logic         kind;
        logic         v;
        logic         rdy;
        logic [W-1:0] data;
        logic [AW-1:0] addr;
        logic         done;
        logic         err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string        nm;
        logic [3:0]   op;
        logic [W-1:0] pl;
        logic         en;
        logic         yumi;
        logic         vin;
        logic [W-1:0] din;
        logic         ev;
        logic         er;
        logic [AW-1:0] ea;
        logic         ed;
        logic         ee;
    } vec_t;
    vec_t vt [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input logic v, input logic r, input logic [W-1:0] d);
        sb.push_back('{1'b0, v, r, d, '0, 1'b0, 1'b0});
    endtask

    task automatic expect_st(input logic [AW-1:0] a, input logic d, input logic e);
        sb.push_back('{1'b1, 1'b0, 1'b0, '0, a, d, e});
    endtask

    task automatic sb_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got empty queue, expected an entry", nm);
            return;
        end
        e = sb.pop_front();
        if (e.kind == 1'b0) begin
            check({nm, ".v_o"},     32'(v_out),    32'(e.v));
            check({nm, ".ready_o"}, 32'(ready),    32'(e.rdy));
            check({nm, ".data_o"},  32'(data_out), 32'(e.data));
        end else begin
            check({nm, ".addr"},    32'(addr),     32'(e.addr));
            check({nm, ".done_o"},  32'(done),     32'(e.done));
            check({nm, ".error_o"}, 32'(err),      32'(e.err));
        end
    endtask

    task automatic load(input logic [W+3:0] a0, input logic [W+3:0] a1,
                        input logic [W+3:0] a2, input logic [W+3:0] a3);
        for (int i = 0; i < 16; i++) rom[i] = 12'h300;
        rom[0] = a0;
        rom[1] = a1;
        rom[2] = a2;
        rom[3] = a3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        en = 1'b1; yumi = 1'b0; v_in = 1'b0; data_in = '0; reset = 1'b1;
        tick();
        if (chk) begin
            expect_out(1'b0, 1'b0, rom[0][W-1:0]);
            sb_check("in_reset");
            expect_st('0, 1'b0, 1'b0);
            sb_check("after_reset");
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected bench to complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; en = 1'b0; yumi = 1'b0; v_in = 1'b0; data_in = '0;

        //        name          op     pl     en  yumi vin din    ev  er  ea  ed  ee
        vt[0]  = '{"wait",      4'h0, 8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'd1,1'b0,1'b0};
        vt[1]  = '{"send_yumi", 4'h1, 8'h5A, 1'b1,1'b1,1'b0,8'h00, 1'b1,1'b0,8'd1,1'b0,1'b0};
        vt[2]  = '{"send_hold", 4'h1, 8'h5A, 1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,8'd0,1'b0,1'b0};
        vt[3]  = '{"recv_ok",   4'h2, 8'h3C, 1'b1,1'b0,1'b1,8'h3C, 1'b0,1'b1,8'd1,1'b0,1'b0};
        vt[4]  = '{"recv_bad",  4'h2, 8'h3C, 1'b1,1'b0,1'b1,8'h3D, 1'b0,1'b1,8'd1,1'b0,1'b1};
        vt[5]  = '{"recv_idle", 4'h2, 8'h3C, 1'b1,1'b0,1'b0,8'h3C, 1'b0,1'b1,8'd0,1'b0,1'b0};
        vt[6]  = '{"done",      4'h3, 8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'd0,1'b1,1'b0};
        vt[7]  = '{"ctr_init",  4'h5, 8'h07, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'd1,1'b0,1'b0};
        vt[8]  = '{"ctr_wait0", 4'h6, 8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'd1,1'b0,1'b0};
        vt[9]  = '{"illegal7",  4'h7, 8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'd0,1'b1,1'b1};
        vt[10] = '{"illegal15", 4'hF, 8'hFF, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,8'd0,1'b1,1'b1};
        vt[11] = '{"en0_send",  4'h1, 8'h66, 1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,8'd0,1'b0,1'b0};
        vt[12] = '{"en0_recv",  4'h2, 8'h44, 1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,8'd0,1'b0,1'b0};

        // Reset behaviour with a SEND sitting at address 0
        load({4'h1, 8'hA5}, 12'h300, 12'h300, 12'h300);
        do_reset(1'b1);

        foreach (vt[i]) begin
            load({vt[i].op, vt[i].pl}, 12'h300, 12'h300, 12'h300);
            do_reset(1'b0);
            en = vt[i].en; yumi = vt[i].yumi; v_in = vt[i].vin; data_in = vt[i].din;
            expect_out(vt[i].ev, vt[i].er, vt[i].pl);
            expect_st(vt[i].ea, vt[i].ed, vt[i].ee);
            #2;
            sb_check({vt[i].nm, "/out"});
            tick();
            en = 1'b1; yumi = 1'b0; v_in = 1'b0;
            sb_check({vt[i].nm, "/state"});
        end

        // SEND held until yumi arrives two cycles late
        load({4'h1, 8'hA5}, 12'h300, 12'h300, 12'h300);
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) begin
            yumi = (c == 2);
            expect_out(1'b1, 1'b0, 8'hA5);
            expect_st(8'd0, 1'b0, 1'b0);
            #2;
            sb_check("send_wait_out");
            sb_check("send_wait_st");
            tick();
        end
        yumi = 1'b0;
        expect_st(8'd1, 1'b0, 1'b0);
        sb_check("send_adv");
        tick();
        expect_st(8'd1, 1'b1, 1'b0);
        expect_out(1'b0, 1'b0, 8'h00);
        sb_check("send_done_st");
        sb_check("send_done_out");

        // RECV match then mismatch, followed by DONE
        for (int k = 0; k < 2; k++) begin
            load({4'h2, 8'h3C}, 12'h300, 12'h300, 12'h300);
            do_reset(1'b0);
            v_in = 1'b1;
            data_in = (k == 1) ? 8'h3D : 8'h3C;
            expect_out(1'b0, 1'b1, 8'h3C);
            #2;
            sb_check("recv_seq_out");
            tick();
            v_in = 1'b0;
            expect_st(8'd1, 1'b0, k[0]);
            sb_check("recv_seq_adv");
            tick();
            expect_st(8'd1, 1'b1, k[0]);
            sb_check("recv_seq_done");
        end

        // Counter load 3 must hold CTR_WAIT for exactly 4 cycles
        begin
            int cyc;
            load({4'h5, 8'h03}, {4'h6, 8'h00}, 12'h300, 12'h300);
            do_reset(1'b0);
            tick();
            expect_st(8'd1, 1'b0, 1'b0);
            sb_check("ctr_loaded");
            cyc = 0;
            while (addr == 8'd1 && cyc < 20) begin
                cyc++;
                tick();
            end
            check("ctr_wait_cycles", 32'(cyc), 32'd4);
            expect_st(8'd2, 1'b0, 1'b0);
            sb_check("ctr_exit");
            tick();
            expect_st(8'd2, 1'b1, 1'b0);
            sb_check("ctr_done");
        end

        // en_i low freezes a pending SEND and ignores yumi
        load({4'h1, 8'h77}, 12'h300, 12'h300, 12'h300);
        do_reset(1'b0);
        en = 1'b0;
        yumi = 1'b1;
        for (int c = 0; c < 5; c++) begin
            expect_out(1'b0, 1'b0, 8'h77);
            expect_st(8'd0, 1'b0, 1'b0);
            #2;
            sb_check("en0_out");
            sb_check("en0_st");
            tick();
        end
        en = 1'b1;
        yumi = 1'b0;
        expect_out(1'b1, 1'b0, 8'h77);
        #2;
        sb_check("en1_out");
        tick();
        expect_st(8'd0, 1'b0, 1'b0);
        sb_check("en1_hold");

        // Illegal opcode latches both flags, then reset clears them
        load({4'h9, 8'h00}, 12'h300, 12'h300, 12'h300);
        do_reset(1'b0);
        tick();
        expect_st(8'd0, 1'b1, 1'b1);
        sb_check("illegal9_st");
        tick();
        expect_st(8'd0, 1'b1, 1'b1);
        expect_out(1'b0, 1'b0, 8'h00);
        sb_check("illegal9_hold");
        sb_check("illegal9_out");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_st(8'd0, 1'b0, 1'b0);
        sb_check("illegal9_reset");

        // Back-to-back SEND, RECV, WAIT, DONE with immediate handshakes
        load({4'h1, 8'h11}, {4'h2, 8'h22}, {4'h0, 8'h00}, {4'h3, 8'h00});
        do_reset(1'b0);
        yumi = 1'b1;
        expect_out(1'b1, 1'b0, 8'h11);
        expect_st(8'd0, 1'b0, 1'b0);
        #2;
        sb_check("b2b_0_out");
        sb_check("b2b_0_st");
        tick();
        yumi = 1'b0; v_in = 1'b1; data_in = 8'h22;
        expect_out(1'b0, 1'b1, 8'h22);
        expect_st(8'd1, 1'b0, 1'b0);
        #2;
        sb_check("b2b_1_out");
        sb_check("b2b_1_st");
        tick();
        v_in = 1'b0;
        expect_out(1'b0, 1'b0, 8'h00);
        expect_st(8'd2, 1'b0, 1'b0);
        sb_check("b2b_2_out");
        sb_check("b2b_2_st");
        tick();
        expect_st(8'd3, 1'b0, 1'b0);
        sb_check("b2b_3_st");
        tick();
        expect_st(8'd3, 1'b1, 1'b0);
        sb_check("b2b_done");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: got %0d leftover entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
